// File: rtl/serial_add_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl_if
// Description : Request/response handshake and adder-slice bus bundle for the
//               nibble-serial add/subtract controller.
// Revision    : 1.0  initial release
// ============================================================================
interface serial_add_ctrl_if #(
   parameter int NIB = 4
);
   // Request channel
   logic             req_valid;
   logic             req_ready;
   logic [4*NIB-1:0] req_a;
   logic [4*NIB-1:0] req_b;
   logic             req_cin;
   logic             req_sub;
   // Response channel
   logic             resp_valid;
   logic             resp_ready;
   logic [4*NIB-1:0] resp_sum;
   logic             resp_cout;
   logic             resp_ovf;
   // Status
   logic             busy;
   // Shared 4-bit adder slice
   logic [3:0]       add_in1;
   logic [3:0]       add_in2;
   logic             add_cin;
   logic [3:0]       add_sum;
   logic             add_cout;

   // Controller side
   modport slave (
      input  req_valid, req_a, req_b, req_cin, req_sub, resp_ready,
             add_sum, add_cout,
      output req_ready, resp_valid, resp_sum, resp_cout, resp_ovf, busy,
             add_in1, add_in2, add_cin
   );

   // Environment side (requester, consumer and adder slice)
   modport master (
      output req_valid, req_a, req_b, req_cin, req_sub, resp_ready,
             add_sum, add_cout,
      input  req_ready, resp_valid, resp_sum, resp_cout, resp_ovf, busy,
             add_in1, add_in2, add_cin
   );
endinterface
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl
// Description : Performs one 4*NIB-bit add/subtract by issuing one nibble at a
//               time (LSB first) to a shared pipelined 4-bit adder slice,
//               chaining the carry through an internal register.
// Revision    : 1.0  initial release
// ============================================================================
module serial_add_ctrl #(
   parameter int NIB     = 4,
   parameter int ADD_LAT = 2
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   serial_add_ctrl_if.slave  bus
);

   localparam int c_W    = 4 * NIB;
   localparam int c_IDXW = (NIB > 1) ? $clog2(NIB) : 1;
   localparam int c_CNTW = $clog2(ADD_LAT + 1);

   localparam logic [c_IDXW-1:0] c_LAST_IDX = c_IDXW'(NIB - 1);
   localparam logic [c_CNTW-1:0] c_CNT_LOAD = c_CNTW'(ADD_LAT);
   localparam logic [c_CNTW-1:0] c_CNT_ONE  = c_CNTW'(1);

   localparam logic [1:0] c_S_IDLE  = 2'd0;
   localparam logic [1:0] c_S_ISSUE = 2'd1;
   localparam logic [1:0] c_S_WAIT  = 2'd2;
   localparam logic [1:0] c_S_RESP  = 2'd3;

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic [c_W-1:0]    r_opa;
   logic [c_W-1:0]    r_opb;
   logic [c_W-1:0]    r_result;
   logic              r_carry;
   logic [c_IDXW-1:0] r_idx;
   logic [c_CNTW-1:0] r_cnt;

   logic              w_accept;
   logic              w_capture;
   logic              w_last;
   logic [3:0]        w_nib_a;
   logic [3:0]        w_nib_b;

   // The slice result is valid in the last WAIT cycle, when the counter
   // loaded with ADD_LAT at ISSUE has counted down to one.
   assign w_accept  = (r_state == c_S_IDLE) && bus.req_valid;
   assign w_capture = (r_state == c_S_WAIT) && (r_cnt == c_CNT_ONE);
   assign w_last    = (r_idx == c_LAST_IDX);
   assign w_nib_a   = r_opa[r_idx*4 +: 4];
   assign w_nib_b   = r_opb[r_idx*4 +: 4];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_S_IDLE:  if (bus.req_valid) w_state_nxt = c_S_ISSUE;
         c_S_ISSUE: w_state_nxt = c_S_WAIT;
         c_S_WAIT:  if (w_capture) w_state_nxt = w_last ? c_S_RESP : c_S_ISSUE;
         c_S_RESP:  if (bus.resp_ready) w_state_nxt = c_S_IDLE;
         default:   w_state_nxt = c_S_IDLE;
      endcase
   end

   // Output logic; the adder slice sees non-zero operands only during ISSUE
   always_comb begin
      bus.req_ready  = (r_state == c_S_IDLE);
      bus.resp_valid = (r_state == c_S_RESP);
      bus.busy       = (r_state != c_S_IDLE);
      bus.add_in1    = 4'd0;
      bus.add_in2    = 4'd0;
      bus.add_cin    = 1'b0;
      if (r_state == c_S_ISSUE) begin
         bus.add_in1 = w_nib_a;
         bus.add_in2 = w_nib_b;
         bus.add_cin = r_carry;
      end
      bus.resp_sum  = r_result;
      bus.resp_cout = r_carry;
      // Signed overflow uses the post-inversion B, so it covers subtract too
      bus.resp_ovf  = (r_opa[c_W-1] == r_opb[c_W-1]) &&
                      (r_result[c_W-1] != r_opa[c_W-1]);
   end

   // Operand latch, carry chain, nibble index, latency counter and result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_opa    <= '0;
         r_opb    <= '0;
         r_result <= '0;
         r_carry  <= 1'b0;
         r_idx    <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_accept) begin
            r_opa   <= bus.req_a;
            r_opb   <= bus.req_sub ? ~bus.req_b : bus.req_b;
            r_carry <= bus.req_sub | bus.req_cin;
            r_idx   <= '0;
         end
         if (r_state == c_S_ISSUE) begin
            r_cnt <= c_CNT_LOAD;
         end
         if (r_state == c_S_WAIT) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (w_capture) begin
            r_result[r_idx*4 +: 4] <= bus.add_sum;
            r_carry                <= bus.add_cout;
            if (!w_last) begin
               r_idx <= r_idx + 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_serial_add_ctrl
// Description : Self-checking bench for serial_add_ctrl with a pipelined
//               4-bit adder slice model and an arithmetic reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_serial_add_ctrl;

   localparam int NIB     = 4;
   localparam int ADD_LAT = 2;
   localparam int W       = 4 * NIB;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   serial_add_ctrl_if #(.NIB(NIB)) u_if ();

   serial_add_ctrl #(.NIB(NIB), .ADD_LAT(ADD_LAT)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if.slave)
   );

   // Pipelined 4-bit adder slice: registered inputs, result after ADD_LAT edges
   logic [4:0] r_pipe [ADD_LAT];
   always @(posedge clk) begin
      r_pipe[0] <= {1'b0, u_if.add_in1} + {1'b0, u_if.add_in2} + {4'b0, u_if.add_cin};
      for (int i = 1; i < ADD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
   end
   assign u_if.add_sum  = r_pipe[ADD_LAT-1][3:0];
   assign u_if.add_cout = r_pipe[ADD_LAT-1][4];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs();
      chk("rst_req_ready",  u_if.req_ready,  1);
      chk("rst_busy",       u_if.busy,       0);
      chk("rst_resp_valid", u_if.resp_valid, 0);
      chk("rst_add_in1",    u_if.add_in1,    0);
      chk("rst_add_in2",    u_if.add_in2,    0);
      chk("rst_add_cin",    u_if.add_cin,    0);
      chk("rst_resp_sum",   u_if.resp_sum,   0);
      chk("rst_resp_cout",  u_if.resp_cout,  0);
      chk("rst_resp_ovf",   u_if.resp_ovf,   0);
   endtask

   // Call at a negedge in an idle cycle; returns at a negedge in an idle cycle.
   // hold: cycles resp_ready stays low after resp_valid; abort_at: cycle after
   // the accept edge in which reset is pulsed (0 = never).
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub,
                         input int hold, input int abort_at);
      logic [W-1:0] bx, esum, mask;
      logic [W:0]   full, part;
      logic         c0, ecout, eovf, eci;
      logic [3:0]   ei1, ei2;
      int           lat, k;
      bx    = sub ? ~b : b;
      c0    = sub ? 1'b1 : cin;
      full  = {1'b0, a} + {1'b0, bx} + (W+1)'(c0);
      esum  = full[W-1:0];
      ecout = full[W];
      eovf  = (a[W-1] == bx[W-1]) && (esum[W-1] != a[W-1]);

      chk("idle_req_ready", u_if.req_ready, 1);
      u_if.req_a     = a;
      u_if.req_b     = b;
      u_if.req_cin   = cin;
      u_if.req_sub   = sub;
      u_if.req_valid = 1'b1;
      lat = 0;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         if (c == 1) u_if.req_valid = 1'b0;
         if (abort_at == c) begin
            rst_n = 1'b0;
            #1;
            chk_reset_outputs();
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         if (u_if.resp_valid) begin
            lat = c;
            break;
         end
         k = (c - 1) / (ADD_LAT + 1);
         ei1 = 4'd0; ei2 = 4'd0; eci = 1'b0;
         if (((c - 1) % (ADD_LAT + 1) == 0) && (k < NIB)) begin
            mask = W'((64'd1 << (4 * k)) - 64'd1);
            part = {1'b0, a & mask} + {1'b0, bx & mask} + (W+1)'(c0);
            ei1  = a[4*k +: 4];
            ei2  = bx[4*k +: 4];
            eci  = part[4*k];
         end
         chk($sformatf("add_in1_c%0d", c), u_if.add_in1, ei1);
         chk($sformatf("add_in2_c%0d", c), u_if.add_in2, ei2);
         chk($sformatf("add_cin_c%0d", c), u_if.add_cin, eci);
         chk("op_busy",      u_if.busy,      1);
         chk("op_req_ready", u_if.req_ready, 0);
      end
      chk("latency", lat, 1 + NIB * (ADD_LAT + 1));
      if (lat == 0) return;

      chk("resp_sum",  u_if.resp_sum,  esum);
      chk("resp_cout", u_if.resp_cout, ecout);
      chk("resp_ovf",  u_if.resp_ovf,  eovf);
      for (int h = 0; h < hold; h++) begin
         // A competing request must be ignored while the response is pending
         u_if.req_a     = ~a;
         u_if.req_b     = a;
         u_if.req_valid = 1'b1;
         @(negedge clk);
         chk("bp_resp_valid", u_if.resp_valid, 1);
         chk("bp_resp_sum",   u_if.resp_sum,   esum);
         chk("bp_resp_cout",  u_if.resp_cout,  ecout);
         chk("bp_resp_ovf",   u_if.resp_ovf,   eovf);
         chk("bp_req_ready",  u_if.req_ready,  0);
         chk("bp_busy",       u_if.busy,       1);
      end
      u_if.req_valid  = 1'b0;
      u_if.resp_ready = 1'b1;
      @(negedge clk);
      u_if.resp_ready = 1'b0;
      chk("post_resp_valid", u_if.resp_valid, 0);
      chk("post_req_ready",  u_if.req_ready,  1);
      chk("post_busy",       u_if.busy,       0);
      chk("post_sum_kept",   u_if.resp_sum,   esum);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      u_if.req_valid  = 1'b0;
      u_if.req_a      = '0;
      u_if.req_b      = '0;
      u_if.req_cin    = 1'b0;
      u_if.req_sub    = 1'b0;
      u_if.resp_ready = 1'b0;
      #1;
      chk_reset_outputs();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Plain add, carry ripple, subtract (cin ignored), signed overflow
      run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 0, 0);
      run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 0);
      run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, 0);
      run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 0);
      run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 0);
      run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, 0);

      // Backpressure, then a request accepted in the first idle cycle
      run_op(16'hA5A5, 16'h1111, 1'b1, 1'b0, 5, 0);
      run_op(16'h0100, 16'h0001, 1'b0, 1'b0, 0, 0);

      // Reset during the third nibble's WAIT, then a clean operation
      run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0, 2 * (ADD_LAT + 1) + 2);
      run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 0);

      // Randomized operations
      for (int n = 0; n < 25; n++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         run_op(ra, rb, 1'($urandom), 1'($urandom), $urandom_range(0, 2), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Sequencer that performs one 4*NIB-bit add or subtract by time-multiplexing a single external pipelined 4-bit adder slice, one nibble at a time, LSB nibble first. Carry is chained between passes through an internal register. Requests arrive and results leave on valid/ready handshakes. It sits between the MAC accumulation control and the shared 4-bit adder slice (registered inputs, registered outputs).

Parameters:
NIB, 4, number of nibbles; operand width is 4*NIB (NIB >= 1).
ADD_LAT, 2, adder slice latency in cycles from driving add_in* to the result being valid on add_sum/add_cout.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request valid
req_ready  output  1  controller can accept a request
req_a  input  4*NIB  operand A
req_b  input  4*NIB  operand B
req_cin  input  1  carry-in; ignored when req_sub=1
req_sub  input  1  1 = A-B (B inverted, carry-in forced to 1)
resp_valid  output  1  result valid
resp_ready  input  1  consumer accepts result
resp_sum  output  4*NIB  result
resp_cout  output  1  final carry out (for sub: 1 = no borrow)
resp_ovf  output  1  two's-complement signed overflow
busy  output  1  high in any state other than IDLE
add_in1  output  4  to adder slice in1
add_in2  output  4  to adder slice in2
add_cin  output  1  to adder slice cin
add_sum  input  4  from adder slice sum
add_cout  input  1  from adder slice cout

Behaviour:
- Reset is asynchronous on rst_n low. All registers clear. State = IDLE. All outputs are 0 except req_ready, which is 1.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. When req_valid is 1:
  - latch A into opa.
  - latch B into opb (~B if req_sub).
  - set the carry register to req_sub ? 1 : req_cin.
  - set the nibble index to 0.
  - go to ISSUE.
- ISSUE (exactly 1 cycle):
  - add_in1 = opa nibble[idx], add_in2 = opb nibble[idx], add_cin = carry register.
  - load the wait counter with ADD_LAT.
  - go to WAIT.
- In every state other than ISSUE, add_in1, add_in2 and add_cin are driven to 0.
- WAIT:
  - the counter decrements each cycle.
  - in the cycle where add_sum is valid (ADD_LAT cycles after ISSUE), capture add_sum into result nibble[idx] and add_cout into the carry register.
  - if idx == NIB-1, go to RESP; otherwise increment idx and go to ISSUE.
- Per-nibble cost is ADD_LAT+1 cycles. If the accept happens at the end of cycle 0, resp_valid rises in cycle 1+NIB*(ADD_LAT+1): cycle 13 for the defaults.
- RESP:
  - resp_valid=1.
  - resp_sum = result, resp_cout = carry register.
  - resp_ovf = (opa MSB == opb MSB) && (result MSB != opa MSB), where opb is the post-inversion value.
  - outputs are held stable while resp_ready=0.
  - on resp_ready=1, go to IDLE; resp_valid drops the next cycle.
- req_ready is 0 in ISSUE, WAIT and RESP. There is no request queueing; a new request can be accepted no earlier than the cycle after the response handshake.
- resp_sum, resp_cout and resp_ovf keep their last values in IDLE. Consumers sample them only when resp_valid=1.
- Reset asserted mid-operation aborts the operation: no response is issued, all state is discarded, and the block returns to the reset values.
- NIB=1 means a single pass. Carry out of the top nibble is never fed back.

Test Plan:
1. Add (NIB=4, ADD_LAT=2): A=0x1234, B=0x0FFF, cin=0, sub=0 -> resp_sum=0x2233, cout=0, ovf=0. resp_valid first high exactly 13 cycles after the accept edge. add_in* non-zero only in cycles 1, 4, 7, 10.
2. Carry ripple: A=0xFFFF, B=0x0001 -> resp_sum=0x0000, cout=1, ovf=0. Intermediate carries are 1 on every nibble pass.
3. Subtract: A=0x0005, B=0x0007, sub=1, cin=1 -> resp_sum=0xFFFE, cout=0, ovf=0. Repeat with cin=0: identical result, since cin is ignored.
4. Signed overflow: A=0x7FFF, B=0x0001 -> 0x8000, cout=0, ovf=1. Sub A=0x8000, B=0x0001 -> 0x7FFF, cout=1, ovf=1.
5. Backpressure: hold resp_ready=0 for 5 cycles after resp_valid rises -> resp_* stable, req_ready=0, busy=1, and a concurrent req_valid is not accepted. Raise resp_ready -> IDLE next cycle, and a new request is accepted one cycle after that.
6. Reset mid-op: assert rst_n=0 during the third nibble's WAIT -> all outputs 0, req_ready=1, busy=0. A following request A=0x00FF, B=0x0001 -> 0x0100 with no leftover carry.
